// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner: synchronizes the rows, rotates the column
// drive once per scan tick and debounces both press and release of one key at a time.
module keypad_scanner #(
  parameter int SCAN_DIV    = 27000,
  parameter int DEBOUNCE_MS = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       keypad_pressed,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEBOUNCE_MS + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_MS);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HOLD     = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      row_meta;
  logic [3:0]      rows_s;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [1:0]      col_idx;
  logic [1:0]      col_next;
  logic [1:0]      row_idx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   rcnt;

  function automatic logic [3:0] col_drive(input logic [1:0] idx);
    col_drive = ~(4'b0001 << idx);
  endfunction

  // Lowest row index wins when several rows are low in the same column.
  function automatic logic [1:0] lowest_zero(input logic [3:0] r);
    if (!r[0]) begin
      lowest_zero = 2'd0;
    end else if (!r[1]) begin
      lowest_zero = 2'd1;
    end else if (!r[2]) begin
      lowest_zero = 2'd2;
    end else begin
      lowest_zero = 2'd3;
    end
  endfunction

  assign tick     = (presc == PRESC_LAST);
  assign col_next = col_idx + 2'd1;

  // Two-flop synchronizer; idles at "no row pulled low".
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta <= 4'hF;
      rows_s   <= 4'hF;
    end else begin
      row_meta <= row;
      rows_s   <= row_meta;
    end
  end

  // Scan-tick prescaler.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Scan / debounce / hold state machine; all transitions happen on tick only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= SCAN;
      col_idx        <= 2'd0;
      col            <= 4'b1110;
      row_idx        <= 2'd0;
      cnt            <= '0;
      rcnt           <= '0;
      keypad_pressed <= 1'b0;
      key_valid      <= 1'b0;
      key_code       <= 4'h0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (rows_s == 4'hF) begin
              col_idx <= col_next;
              col     <= col_drive(col_next);
            end else begin
              row_idx <= lowest_zero(rows_s);
              cnt     <= CW'(1);
              state   <= DEBOUNCE;
            end
          end
          DEBOUNCE: begin
            if (!rows_s[row_idx]) begin
              if (cnt + CW'(1) == DB_LAST) begin
                state          <= HOLD;
                key_valid      <= 1'b1;
                keypad_pressed <= 1'b1;
                key_code       <= {row_idx, col_idx};
                rcnt           <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else begin
              state   <= SCAN;
              col_idx <= col_next;
              col     <= col_drive(col_next);
            end
          end
          HOLD: begin
            // Any low sample during release restarts the release count.
            if (rows_s[row_idx]) begin
              if (rcnt + CW'(1) == DB_LAST) begin
                state          <= SCAN;
                keypad_pressed <= 1'b0;
                col_idx        <= col_next;
                col            <= col_drive(col_next);
                rcnt           <= '0;
              end else begin
                rcnt <= rcnt + CW'(1);
              end
            end else begin
              rcnt <= '0;
            end
          end
          default: begin
            state          <= SCAN;
            col_idx        <= 2'd0;
            col            <= 4'b1110;
            keypad_pressed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the column
// drive; accepted key codes are predicted into a queue and checked by a monitor.
module tb_keypad_scanner;

  logic       clk;
  logic       rst;
  logic [3:0] row;
  logic [3:0] col;
  logic       keypad_pressed;
  logic       key_valid;
  logic [3:0] key_code;

  logic [15:0] keys;
  logic [3:0]  exp_q[$];
  logic        prev_valid;
  int          checks;
  int          fails;
  int          n;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_MS(3)) dut (
    .clk            (clk),
    .rst            (rst),
    .row            (row),
    .col            (col),
    .keypad_pressed (keypad_pressed),
    .key_valid      (key_valid),
    .key_code       (key_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Physical matrix: key r*4+c pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && (col[c] === 1'b0)) row[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_pressed(input logic val, input int maxc, output int cyc);
    cyc = 0;
    while (keypad_pressed !== val && cyc < maxc) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Scoreboard monitor: every key_valid must match the oldest predicted code.
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious key_valid (queue size)", 32'(exp_q.size()), 32'd1);
      end else begin
        check("key_code at key_valid", 32'(key_code), 32'(exp_q.pop_front()));
        check("keypad_pressed with key_valid", 32'(keypad_pressed), 32'd1);
      end
    end
    if (prev_valid) check("key_valid one clk wide", 32'(key_valid), 32'd0);
    prev_valid <= key_valid;
  end

  initial begin
    logic [3:0] idle_seq [5];
    logic [3:0] c0;
    idle_seq   = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    checks     = 0;
    fails      = 0;
    keys       = 16'h0000;
    prev_valid = 1'b0;
    rst        = 1'b1;
    do_reset();

    // Reset state and idle rotation
    check("reset col", 32'(col), 32'(idle_seq[0]));
    check("reset keypad_pressed", 32'(keypad_pressed), 32'd0);
    check("reset key_valid", 32'(key_valid), 32'd0);
    check("reset key_code", 32'(key_code), 32'd0);
    for (int i = 1; i < 5; i++) begin
      repeat (4) @(negedge clk);
      check($sformatf("idle col step %0d", i), 32'(col), 32'(idle_seq[i]));
      check("idle keypad_pressed", 32'(keypad_pressed), 32'd0);
    end

    // Clean press of row 2 / column 1, then release
    keys[9] = 1'b1;
    exp_q.push_back(4'h9);
    repeat (40) @(negedge clk);
    check("clean press held", 32'(keypad_pressed), 32'd1);
    check("clean press col frozen", 32'(col), 32'(4'b1101));
    check("clean press key_code", 32'(key_code), 32'h9);
    keys = 16'h0000;
    wait_pressed(1'b0, 30, n);
    check("clean release", 32'(keypad_pressed), 32'd0);
    check("clean release latency in 11..14", 32'(n >= 11 && n <= 14), 32'd1);
    check("rotation resumes", 32'(col), 32'(4'b1011));

    // Press bounce: row 0 / column 2 low for two ticks only
    keys[2] = 1'b1;
    repeat (8) @(negedge clk);
    keys = 16'h0000;
    repeat (16) @(negedge clk);
    check("bounce no press", 32'(keypad_pressed), 32'd0);
    c0 = col;
    repeat (4) @(negedge clk);
    check("bounce scanning continues", 32'(col), 32'({c0[2:0], c0[3]}));

    // Release bounce while holding row 1 / column 0
    keys[4] = 1'b1;
    exp_q.push_back(4'h4);
    wait_pressed(1'b1, 40, n);
    check("hold press accepted", 32'(keypad_pressed), 32'd1);
    keys = 16'h0000;
    repeat (8) @(negedge clk);
    keys[4] = 1'b1;
    repeat (4) @(negedge clk);
    check("release bounce still held", 32'(keypad_pressed), 32'd1);
    keys = 16'h0000;
    wait_pressed(1'b0, 30, n);
    check("release after bounce", 32'(keypad_pressed), 32'd0);
    check("release-bounce latency in 11..14", 32'(n >= 11 && n <= 14), 32'd1);

    // Two keys in column 3: row 1 wins, releasing row 3 is ignored
    keys[7]  = 1'b1;
    keys[15] = 1'b1;
    exp_q.push_back(4'h7);
    wait_pressed(1'b1, 40, n);
    check("two-key press", 32'(keypad_pressed), 32'd1);
    check("two-key key_code", 32'(key_code), 32'h7);
    keys[15] = 1'b0;
    repeat (40) @(negedge clk);
    check("other key release ignored", 32'(keypad_pressed), 32'd1);
    check("two-key col frozen", 32'(col), 32'(4'b0111));
    keys[7] = 1'b0;
    wait_pressed(1'b0, 30, n);
    check("two-key release", 32'(keypad_pressed), 32'd0);
    check("col wraps to 0", 32'(col), 32'(4'b1110));

    // Reset mid-HOLD with row 2 / column 3 still held
    keys[11] = 1'b1;
    exp_q.push_back(4'hB);
    wait_pressed(1'b1, 40, n);
    check("pre-reset press", 32'(keypad_pressed), 32'd1);
    do_reset();
    check("mid-hold reset pressed", 32'(keypad_pressed), 32'd0);
    check("mid-hold reset col", 32'(col), 32'(4'b1110));
    check("mid-hold reset key_code", 32'(key_code), 32'h0);
    check("mid-hold reset key_valid", 32'(key_valid), 32'd0);
    exp_q.push_back(4'hB);
    wait_pressed(1'b1, 40, n);
    check("re-accept after reset", 32'(keypad_pressed), 32'd1);
    check("re-accept key_code", 32'(key_code), 32'hB);
    keys = 16'h0000;
    wait_pressed(1'b0, 30, n);
    check("final release", 32'(keypad_pressed), 32'd0);

    repeat (4) @(negedge clk);
    check("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
